// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin arbiter of two burst masters onto one SDRAM controller port,
// tracking outstanding reads in a FIFO to route returned read data to the right master.
module sdram_arbiter #(
    parameter int RD_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [24:0] m0_address,
    input  logic [15:0] m0_writedata,
    input  logic [1:0]  m0_byteenable,
    input  logic [6:0]  m0_burstcount,
    input  logic        m0_read,
    input  logic        m0_write,
    output logic [15:0] m0_readdata,
    output logic        m0_waitrequest,
    output logic        m0_readdatavalid,
    input  logic [24:0] m1_address,
    input  logic [15:0] m1_writedata,
    input  logic [1:0]  m1_byteenable,
    input  logic [6:0]  m1_burstcount,
    input  logic        m1_read,
    input  logic        m1_write,
    output logic [15:0] m1_readdata,
    output logic        m1_waitrequest,
    output logic        m1_readdatavalid,
    output logic [24:0] dbus_address,
    output logic [15:0] dbus_writedata,
    output logic [1:0]  dbus_byteenable,
    output logic [6:0]  dbus_burstcount,
    output logic        dbus_read,
    output logic        dbus_write,
    input  logic [15:0] dbus_readdata,
    input  logic        dbus_waitrequest,
    input  logic        dbus_readdatavalid,
    output logic        rd_err
);
    localparam int AW = $clog2(RD_DEPTH);
    localparam logic [1:0] IDLE = 2'd0, WR_BURST = 2'd1, RD_CMD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        g_q, g_d, lg_q, lg_d;
    logic [6:0]  rem_q, rem_d, beat_q, beat_d;
    logic [AW:0] wp_q, rp_q;
    logic        rd_err_q;
    logic        id_mem [RD_DEPTH];
    logic [6:0]  cnt_mem [RD_DEPTH];

    logic empty, full, req0, req1, gn, gw, busy, sel, mg_read, mg_write;
    logic push, pop, rdv_ok, head_id, last_beat;
    logic [6:0] gbc, head_cnt;

    assign empty = wp_q == rp_q;
    assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign req0 = m0_write | (m0_read & ~full);
    assign req1 = m1_write | (m1_read & ~full);
    assign gn = (req0 & req1) ? ~lg_q : req1;
    assign gw = gn ? m1_write : m0_write;
    assign gbc = gn ? m1_burstcount : m0_burstcount;

    // In IDLE the command bus shows master 0 with both strobes low.
    assign busy = state_q != IDLE;
    assign sel = busy & g_q;
    assign mg_read = g_q ? m1_read : m0_read;
    assign mg_write = g_q ? m1_write : m0_write;
    assign dbus_address = sel ? m1_address : m0_address;
    assign dbus_writedata = sel ? m1_writedata : m0_writedata;
    assign dbus_byteenable = sel ? m1_byteenable : m0_byteenable;
    assign dbus_burstcount = sel ? m1_burstcount : m0_burstcount;
    assign dbus_read = (state_q == RD_CMD) & mg_read;
    assign dbus_write = (state_q == WR_BURST) & mg_write;
    assign m0_waitrequest = (busy & ~g_q) ? dbus_waitrequest : 1'b1;
    assign m1_waitrequest = (busy & g_q) ? dbus_waitrequest : 1'b1;

    assign push = (state_q == RD_CMD) & mg_read & ~dbus_waitrequest;
    assign rdv_ok = dbus_readdatavalid & ~empty;
    assign head_id = id_mem[rp_q[AW-1:0]];
    assign head_cnt = cnt_mem[rp_q[AW-1:0]];
    assign last_beat = 7'(beat_q + 7'd1) == head_cnt;
    assign pop = rdv_ok & last_beat;
    assign m0_readdata = dbus_readdata;
    assign m1_readdata = dbus_readdata;
    assign m0_readdatavalid = rdv_ok & ~head_id;
    assign m1_readdatavalid = rdv_ok & head_id;
    assign rd_err = rd_err_q;

    always_comb begin
        state_d = state_q;
        g_d = g_q;
        lg_d = lg_q;
        rem_d = rem_q;
        if (state_q == IDLE) begin
            if (req0 | req1) begin
                g_d = gn;
                lg_d = gn;
                rem_d = (gbc == 7'd0) ? 7'd1 : gbc;
                state_d = gw ? WR_BURST : RD_CMD;
            end
        end else if (state_q == WR_BURST) begin
            if (mg_write & ~dbus_waitrequest) begin
                rem_d = rem_q - 7'd1;
                state_d = (rem_q == 7'd1) ? IDLE : WR_BURST;
            end
        end else if (~mg_read | ~dbus_waitrequest) begin
            state_d = IDLE;
        end
        beat_d = rdv_ok ? (last_beat ? 7'd0 : 7'(beat_q + 7'd1)) : beat_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            g_q <= 1'b0;
            lg_q <= 1'b1;
            rem_q <= 7'd0;
            beat_q <= 7'd0;
            wp_q <= '0;
            rp_q <= '0;
            rd_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q <= g_d;
            lg_q <= lg_d;
            rem_q <= rem_d;
            beat_q <= beat_d;
            wp_q <= push ? wp_q + 1'b1 : wp_q;
            rp_q <= pop ? rp_q + 1'b1 : rp_q;
            rd_err_q <= rd_err_q | (dbus_readdatavalid & empty);
        end
    end

    // In RD_CMD rem_q still holds the normalised burst length of the command.
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wp_q[AW-1:0]] <= g_q;
            cnt_mem[wp_q[AW-1:0]] <= rem_q;
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed self-checking bench for sdram_arbiter.
module tb_sdram_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] m0_address, m1_address, dbus_address;
    logic [15:0] m0_writedata, m1_writedata, dbus_writedata;
    logic [1:0]  m0_byteenable, m1_byteenable, dbus_byteenable;
    logic [6:0]  m0_burstcount, m1_burstcount, dbus_burstcount;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [15:0] m0_readdata, m1_readdata, dbus_readdata;
    logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
    logic        dbus_read, dbus_write, dbus_waitrequest, dbus_readdatavalid, rd_err;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(.RD_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .m0_address(m0_address), .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_burstcount(m0_burstcount), .m0_read(m0_read), .m0_write(m0_write),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_burstcount(m1_burstcount), .m1_read(m1_read), .m1_write(m1_write),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid),
        .dbus_address(dbus_address), .dbus_writedata(dbus_writedata), .dbus_byteenable(dbus_byteenable),
        .dbus_burstcount(dbus_burstcount), .dbus_read(dbus_read), .dbus_write(dbus_write),
        .dbus_readdata(dbus_readdata), .dbus_waitrequest(dbus_waitrequest),
        .dbus_readdatavalid(dbus_readdatavalid), .rd_err(rd_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, cyc, m0bad, n;
        rst = 1'b0;
        {m0_address, m0_writedata, m0_byteenable, m0_burstcount, m0_read, m0_write} = '0;
        {m1_address, m1_writedata, m1_byteenable, m1_burstcount, m1_read, m1_write} = '0;
        {dbus_readdata, dbus_waitrequest, dbus_readdatavalid} = '0;
        #3;
        chk("rst_dbus_rw", {dbus_read, dbus_write}, 2'b00);
        chk("rst_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
        chk("rst_rdv_err", {m0_readdatavalid, m1_readdatavalid, rd_err}, 3'b000);
        tick();
        tick();
        rst = 1'b1;

        // Simultaneous single-word writes: m0 wins the first tie
        m0_write = 1; m0_burstcount = 1; m0_writedata = 16'h5555;
        m1_write = 1; m1_burstcount = 1; m1_writedata = 16'hAAAA;
        #1;
        chk("tie_idle_wait", {dbus_write, m0_waitrequest, m1_waitrequest}, 3'b011);
        tick();
        chk("tie_g0", {dbus_write, m0_waitrequest, m1_waitrequest}, 3'b101);
        chk("tie_g0_data", dbus_writedata, 16'h5555);
        tick();
        m0_write = 0;
        #1;
        chk("tie_idle2", {dbus_write, m1_waitrequest}, 2'b01);
        tick();
        chk("tie_g1", {dbus_write, m0_waitrequest, m1_waitrequest}, 3'b110);
        chk("tie_g1_data", dbus_writedata, 16'hAAAA);
        tick();
        m1_write = 0;

        // m1 burst of 8 with toggling waitrequest and one paused cycle
        m1_write = 1; m1_burstcount = 8; m1_writedata = 16'h1234;
        tick();
        beats = 0; cyc = 0; m0bad = 0;
        while (beats < 8 && cyc < 40) begin
            dbus_waitrequest = cyc[0];
            m1_write = (cyc != 4);
            #1;
            if (m0_waitrequest !== 1'b1) m0bad++;
            if (dbus_write && !dbus_waitrequest) beats++;
            tick();
            cyc++;
        end
        dbus_waitrequest = 0;
        #1;
        chk("b8_beats", beats, 8);
        chk("b8_m0_wait", m0bad, 0);
        chk("b8_cycles", cyc, 17);
        chk("b8_idle", {dbus_write, m1_waitrequest}, 2'b01);
        m1_write = 0;

        // m0 read burst 5, then m1 read burst 1
        m0_read = 1; m0_burstcount = 5; m0_address = 25'h0ABCDE;
        tick();
        chk("rd0_cmd", {dbus_read, m0_waitrequest}, 2'b10);
        chk("rd0_addr", dbus_address, 25'h0ABCDE);
        tick();
        m0_read = 0;
        m1_read = 1; m1_burstcount = 1; m1_address = 25'h1000001;
        tick();
        chk("rd1_cmd", {dbus_read, m1_waitrequest}, 2'b10);
        chk("rd1_addr", dbus_address, 25'h1000001);
        tick();
        m1_read = 0;
        for (int i = 0; i < 6; i++) begin
            dbus_readdatavalid = 1; dbus_readdata = 16'h0100 + 16'(i);
            #1;
            chk($sformatf("rdv_beat%0d", i), {m0_readdatavalid, m1_readdatavalid}, (i < 5) ? 2'b10 : 2'b01);
            if (i == 2) chk("rdata_m0", m0_readdata, 16'h0102);
            if (i == 5) chk("rdata_m1", m1_readdata, 16'h0105);
            tick();
        end
        dbus_readdatavalid = 0;
        chk("rd_err_clean", rd_err, 0);

        // Fill the tracking FIFO with four m0 reads of 2 beats
        for (int i = 0; i < 4; i++) begin
            m0_read = 1; m0_burstcount = 2;
            tick();
            tick();
        end
        m1_write = 1; m1_burstcount = 1; m1_writedata = 16'hBEEF;
        #1;
        chk("full_idle", m0_waitrequest, 1);
        tick();
        chk("full_wr_grant", {dbus_write, dbus_read, m0_waitrequest, m1_waitrequest}, 4'b1010);
        tick();
        m1_write = 0;
        tick();
        chk("full_masked", {dbus_read, m0_waitrequest}, 2'b01);
        dbus_readdatavalid = 1;
        #1;
        chk("full_ret1", m0_readdatavalid, 1);
        tick();
        chk("full_ret2", {m0_readdatavalid, m0_waitrequest}, 2'b11);
        tick();
        dbus_readdatavalid = 0;
        #1;
        chk("full_after_pop", m0_waitrequest, 1);
        tick();
        chk("full_5th_grant", {dbus_read, m0_waitrequest}, 2'b10);
        tick();
        m0_read = 0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            dbus_readdatavalid = 1;
            #1;
            n += int'(m0_readdatavalid) + 10 * int'(m1_readdatavalid);
            tick();
        end
        dbus_readdatavalid = 0;
        chk("drain_beats", n, 8);
        chk("drain_no_err", rd_err, 0);

        // Stray readdatavalid with nothing outstanding
        dbus_readdatavalid = 1;
        #1;
        chk("stray_no_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
        tick();
        dbus_readdatavalid = 0;
        chk("stray_err", rd_err, 1);
        tick();
        tick();
        chk("stray_sticky", rd_err, 1);

        // Reset during beat 3 of an m0 write burst, with an m1 read outstanding
        m1_read = 1; m1_burstcount = 1;
        tick();
        tick();
        m1_read = 0;
        m0_write = 1; m0_burstcount = 8; m0_writedata = 16'h7777;
        tick();
        tick();
        tick();
        chk("rst_beat3_pre", dbus_write, 1);
        rst = 0;
        #1;
        chk("rst_beat3_drop", {dbus_write, m0_waitrequest, m1_waitrequest}, 3'b011);
        chk("rst_beat3_err", rd_err, 0);
        tick();
        rst = 1;
        m0_write = 0;
        m1_write = 1; m1_burstcount = 1; m1_writedata = 16'h4321;
        tick();
        chk("post_rst_grant", {dbus_write, m0_waitrequest, m1_waitrequest}, 3'b110);
        chk("post_rst_data", dbus_writedata, 16'h4321);
        tick();
        m1_write = 0;
        dbus_readdatavalid = 1;
        #1;
        chk("post_rst_no_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
        tick();
        dbus_readdatavalid = 0;
        chk("post_rst_err", rd_err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
